// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module   : alu
// Purpose  : 8-bit, 16-function ALU with registered result, MUL high byte
//            and C/Z/N/V status flags; one-cycle latency.
// Revision : 1.0 - initial release
// ============================================================================
module alu (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic [3:0] function_select_lines,
  output logic [7:0] reg_out,
  output logic [7:0] mul_high,
  output logic [3:0] SREG
);

  localparam logic [3:0] c_op_pass = 4'd0;
  localparam logic [3:0] c_op_add  = 4'd1;
  localparam logic [3:0] c_op_sub  = 4'd2;
  localparam logic [3:0] c_op_cmp  = 4'd3;
  localparam logic [3:0] c_op_mul  = 4'd4;
  localparam logic [3:0] c_op_and  = 4'd5;
  localparam logic [3:0] c_op_or   = 4'd6;
  localparam logic [3:0] c_op_xor  = 4'd7;
  localparam logic [3:0] c_op_not  = 4'd8;
  localparam logic [3:0] c_op_nand = 4'd9;
  localparam logic [3:0] c_op_lsl  = 4'd10;
  localparam logic [3:0] c_op_lsr  = 4'd11;
  localparam logic [3:0] c_op_asr  = 4'd12;
  localparam logic [3:0] c_op_rol  = 4'd13;
  localparam logic [3:0] c_op_ror  = 4'd14;
  localparam logic [3:0] c_op_nor  = 4'd15;

  logic [2:0]  w_amt;
  logic [8:0]  w_sum;
  logic [8:0]  w_diff;
  logic        w_add_v;
  logic        w_sub_v;
  logic [15:0] w_prod;
  logic [15:0] w_lsl;
  logic [15:0] w_lsr;
  logic [15:0] w_asr;
  logic [15:0] w_rol;
  logic [15:0] w_ror;

  logic [7:0]  w_res;
  logic [7:0]  w_mul_high;
  logic        w_c;
  logic        w_z;
  logic        w_n;
  logic        w_v;
  logic        w_amt_nz;

  logic [7:0]  r_reg_out;
  logic [7:0]  r_mul_high;
  logic [3:0]  r_sreg;

  assign w_amt    = B[2:0];
  assign w_amt_nz = (w_amt != 3'd0);
  assign w_sum    = {1'b0, A} + {1'b0, B};
  assign w_diff   = {1'b0, A} - {1'b0, B};
  assign w_add_v  = (A[7] == B[7]) && (w_sum[7] != A[7]);
  assign w_sub_v  = (A[7] != B[7]) && (w_diff[7] != A[7]);
  assign w_prod   = {8'd0, A} * {8'd0, B};

  // Shifts run in a 16-bit window so the last bit shifted out lands in a
  // fixed position next to the result byte (bit 8 for LSL, bit 7 for right).
  assign w_lsl = {8'd0, A} << w_amt;
  assign w_lsr = {A, 8'd0} >> w_amt;
  assign w_asr = $signed({A, 8'd0}) >>> w_amt;
  assign w_rol = {A, A} << w_amt;
  assign w_ror = {A, A} >> w_amt;

  always_comb begin
    w_res      = 8'd0;
    w_mul_high = 8'd0;
    w_c        = 1'b0;
    w_v        = 1'b0;
    case (function_select_lines)
      c_op_pass: w_res = A;
      c_op_add: begin
        w_res = w_sum[7:0];
        w_c   = w_sum[8];
        w_v   = w_add_v;
      end
      c_op_sub: begin
        w_res = w_diff[7:0];
        w_c   = w_diff[8];
        w_v   = w_sub_v;
      end
      c_op_cmp: begin
        w_res = {5'd0, (A > B), (A == B), (A < B)};
        w_c   = w_diff[8];
        w_v   = w_sub_v;
      end
      c_op_mul: begin
        w_res      = w_prod[7:0];
        w_mul_high = w_prod[15:8];
        w_c        = (w_prod[15:8] != 8'd0);
      end
      c_op_and:  w_res = A & B;
      c_op_or:   w_res = A | B;
      c_op_xor:  w_res = A ^ B;
      c_op_not:  w_res = ~A;
      c_op_nand: w_res = ~(A & B);
      c_op_nor:  w_res = ~(A | B);
      c_op_lsl: begin
        w_res = w_lsl[7:0];
        w_c   = w_lsl[8];
      end
      c_op_lsr: begin
        w_res = w_lsr[15:8];
        w_c   = w_lsr[7];
      end
      c_op_asr: begin
        w_res = w_asr[15:8];
        w_c   = w_asr[7];
      end
      c_op_rol: begin
        w_res = w_rol[15:8];
        w_c   = w_amt_nz & w_rol[8];
      end
      c_op_ror: begin
        w_res = w_ror[7:0];
        w_c   = w_amt_nz & w_ror[7];
      end
      default: w_res = 8'd0;
    endcase
  end

  // CMP reports Z/N of the subtraction and MUL of the full product.
  always_comb begin
    w_z = (w_res == 8'd0);
    w_n = w_res[7];
    if (function_select_lines == c_op_cmp) begin
      w_z = (w_diff[7:0] == 8'd0);
      w_n = w_diff[7];
    end else if (function_select_lines == c_op_mul) begin
      w_z = (w_prod == 16'd0);
      w_n = w_prod[15];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reg_out  <= 8'd0;
      r_mul_high <= 8'd0;
      r_sreg     <= 4'd0;
    end else begin
      r_reg_out  <= w_res;
      r_mul_high <= w_mul_high;
      r_sreg     <= {w_v, w_n, w_z, w_c};
    end
  end

  assign reg_out  = r_reg_out;
  assign mul_high = r_mul_high;
  assign SREG     = r_sreg;

endmodule
`default_nettype wire

// File: tb/tb_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu
// Purpose  : Self-checking bench for alu: directed vectors, timing/reset
//            cases and randomized ops against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu;

  logic       clk;
  logic       rst_n;
  logic [7:0] A;
  logic [7:0] B;
  logic [3:0] fsel;
  logic [7:0] reg_out;
  logic [7:0] mul_high;
  logic [3:0] SREG;

  int n_checks = 0;
  int n_errors = 0;

  alu dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .A                     (A),
    .B                     (B),
    .function_select_lines (fsel),
    .reg_out               (reg_out),
    .mul_high              (mul_high),
    .SREG                  (SREG)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic int to_signed(input int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  // Returns {mul_high, reg_out, V, N, Z, C}.
  function automatic logic [19:0] model(input int a, input int b, input int op);
    int r, mh, c, v, z, n, amt, t, bit_out;
    r = a; mh = 0; c = 0; v = 0; amt = b % 8; t = 0;
    case (op)
      0: r = a;
      1: begin
        t = a + b; r = t % 256; c = (t > 255) ? 1 : 0;
        t = to_signed(a) + to_signed(b); v = (t > 127 || t < -128) ? 1 : 0;
      end
      2, 3: begin
        r = (a - b + 256) % 256; c = (a < b) ? 1 : 0;
        t = to_signed(a) - to_signed(b); v = (t > 127 || t < -128) ? 1 : 0;
      end
      4: begin t = a * b; r = t % 256; mh = t / 256; c = (mh != 0) ? 1 : 0; end
      5: r = a & b;
      6: r = a | b;
      7: r = a ^ b;
      8: r = 255 - a;
      9: r = 255 - (a & b);
      15: r = 255 - (a | b);
      10: for (int i = 0; i < amt; i++) begin c = r / 128; r = (r * 2) % 256; end
      11: for (int i = 0; i < amt; i++) begin c = r % 2; r = r / 2; end
      12: for (int i = 0; i < amt; i++) begin c = r % 2; r = r / 2 + ((r >= 128) ? 128 : 0); end
      13: begin
        for (int i = 0; i < amt; i++) begin bit_out = r / 128; r = (r * 2) % 256 + bit_out; end
        c = (amt != 0) ? r % 2 : 0;
      end
      14: begin
        for (int i = 0; i < amt; i++) begin bit_out = r % 2; r = r / 2 + bit_out * 128; end
        c = (amt != 0) ? r / 128 : 0;
      end
      default: r = 0;
    endcase
    z = (r == 0) ? 1 : 0;
    n = r / 128;
    if (op == 4) begin
      z = (t == 0) ? 1 : 0;
      n = mh / 128;
    end
    if (op == 3)
      r = ((a > b) ? 4 : 0) + ((a == b) ? 2 : 0) + ((a < b) ? 1 : 0);
    return {mh[7:0], r[7:0], v[0], n[0], z[0], c[0]};
  endfunction

  task automatic apply(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    @(negedge clk);
    A = a; B = b; fsel = op;
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag, input logic [7:0] a, input logic [7:0] b,
                             input logic [3:0] op);
    logic [19:0] e;
    e = model(int'(a), int'(b), int'(op));
    check({tag, ".reg_out"}, {24'd0, reg_out}, {24'd0, e[11:4]});
    check({tag, ".sreg"}, {28'd0, SREG}, {28'd0, e[3:0]});
    check({tag, ".mul_high"}, {24'd0, mul_high}, {24'd0, e[19:12]});
  endtask

  // Directed vectors: a, b, op, expected reg_out, mul_high, SREG {V,N,Z,C}.
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] op;
    logic [7:0] res;
    logic [7:0] mh;
    logic [3:0] sreg;
  } vec_t;

  vec_t vecs[] = '{
    '{8'd6,   8'd9,   4'd1,  8'h0F, 8'h00, 4'b0000},
    '{8'd3,   8'd6,   4'd2,  8'hFD, 8'h00, 4'b0101},
    '{8'd127, 8'd1,   4'd1,  8'h80, 8'h00, 4'b1100},
    '{8'd127, 8'd125, 4'd3,  8'h04, 8'h00, 4'b0000},
    '{8'd5,   8'd5,   4'd3,  8'h02, 8'h00, 4'b0010},
    '{8'd1,   8'd2,   4'd4,  8'h02, 8'h00, 4'b0000},
    '{8'hFF,  8'hFE,  4'd4,  8'h02, 8'hFD, 4'b0101},
    '{8'd13,  8'd85,  4'd5,  8'h05, 8'h00, 4'b0000},
    '{8'd13,  8'd85,  4'd6,  8'h5D, 8'h00, 4'b0000},
    '{8'd13,  8'd85,  4'd7,  8'h58, 8'h00, 4'b0000},
    '{8'd120, 8'd85,  4'd8,  8'h87, 8'h00, 4'b0100},
    '{8'd5,   8'd5,   4'd10, 8'hA0, 8'h00, 4'b0100},
    '{8'h81,  8'd0,   4'd13, 8'h81, 8'h00, 4'b0100},
    '{8'h81,  8'd8,   4'd14, 8'h81, 8'h00, 4'b0100},
    '{8'h81,  8'd1,   4'd11, 8'h40, 8'h00, 4'b0001},
    '{8'h81,  8'd1,   4'd12, 8'hC0, 8'h00, 4'b0101}
  };

  initial begin
    rst_n = 1'b0; A = 8'd0; B = 8'd0; fsel = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.reg_out", {24'd0, reg_out}, 32'd0);
    check("reset.mul_high", {24'd0, mul_high}, 32'd0);
    check("reset.sreg", {28'd0, SREG}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      apply(vecs[i].a, vecs[i].b, vecs[i].op);
      check($sformatf("dir%0d.reg_out", i), {24'd0, reg_out}, {24'd0, vecs[i].res});
      check($sformatf("dir%0d.mul_high", i), {24'd0, mul_high}, {24'd0, vecs[i].mh});
      check($sformatf("dir%0d.sreg", i), {28'd0, SREG}, {28'd0, vecs[i].sreg});
    end

    // ROR result must stay put across consecutive edges with fixed inputs.
    apply(8'hFF, 8'hFE, 4'd14);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("ror_stable%0d.reg_out", i), {24'd0, reg_out}, 32'h0000_00FF);
      check($sformatf("ror_stable%0d.sreg", i), {28'd0, SREG}, 32'h0000_0005);
      @(posedge clk);
      #1;
    end

    // Outputs hold when inputs change between edges.
    apply(8'd6, 8'd9, 4'd1);
    A = 8'd200; fsel = 4'd4;
    #2;
    check("hold.reg_out", {24'd0, reg_out}, 32'h0000_000F);
    check("hold.mul_high", {24'd0, mul_high}, 32'd0);
    @(posedge clk);
    #1;
    check_model("hold_next", 8'd200, 8'd9, 4'd4);

    // Asynchronous reset during a MUL, then recovery on the first edge.
    apply(8'hFF, 8'hFE, 4'd4);
    @(negedge clk);
    A = 8'hF0; B = 8'hF0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst.reg_out", {24'd0, reg_out}, 32'd0);
    check("async_rst.mul_high", {24'd0, mul_high}, 32'd0);
    check("async_rst.sreg", {28'd0, SREG}, 32'd0);
    @(posedge clk);
    #1;
    check("held_rst.mul_high", {24'd0, mul_high}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    A = 8'd3; B = 8'd4; fsel = 4'd1;
    @(posedge clk);
    #1;
    check("post_rst.reg_out", {24'd0, reg_out}, 32'h0000_0007);
    check_model("post_rst", 8'd3, 8'd4, 4'd1);

    for (int i = 0; i < 400; i++) begin
      logic [7:0] ra, rb;
      logic [3:0] rop;
      ra  = 8'($urandom_range(0, 255));
      rb  = 8'($urandom_range(0, 255));
      rop = 4'($urandom_range(0, 15));
      if (i % 8 == 0) rb = ra;
      apply(ra, rb, rop);
      check_model($sformatf("rnd%0d_op%0d", i, rop), ra, rb, rop);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
